// File: rtl/game_timer_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_timer_bank_pkg
// Description : Shared game definitions for the timer bank. Holds the
//               GameState code width and the GameState encodings used to
//               enable individual timer channels.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package game_timer_bank_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        GS_IDLE    = 4'b0000,
        GS_PLAYING = 4'b0011,
        GS_END     = 4'b0101,
        GS_KO      = 4'b0110,
        GS_PAUSE3  = 4'b1000,
        GS_PAUSE4  = 4'b1001
    } game_state_e;

endpackage
`default_nettype wire

// File: rtl/game_timer_bank_channel.sv
`default_nettype none
// ============================================================================
// Module      : game_timer_channel
// Description : One saturating game timer. A private prescaler divides the
//               clock by TICK_DIV while the channel is active; every tick
//               steps the count one value toward its terminal value, where it
//               saturates. Any GameState other than STATE, or a restart,
//               reloads the channel.
// Ports       : clk          in  clock, rising edge
//               reset_n      in  synchronous active-low reset
//               game_state   in  current GameState code
//               pause        in  freeze prescaler and count
//               restart      in  reload request
//               count        out registered channel count
//               expired      out high while count equals the terminal value
//               expire_pulse out one-cycle strobe on stepping into terminal
// Revision    : 1.0 - initial release
// ============================================================================
module game_timer_channel
    import game_timer_bank_pkg::*;
#(
    parameter int                 CNT_W    = 4,
    parameter int                 TICK_DIV = 50000000,
    parameter logic [STATE_W-1:0] STATE    = GS_PLAYING,
    parameter logic [CNT_W-1:0]   LIMIT    = CNT_W'(15),
    parameter bit                 DOWN     = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [STATE_W-1:0] game_state,
    input  logic               pause,
    input  logic               restart,
    output logic [CNT_W-1:0]   count,
    output logic               expired,
    output logic               expire_pulse
);

    localparam int               PRE_W         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST      = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] START_VAL     = DOWN ? LIMIT : '0;
    localparam logic [CNT_W-1:0] TERM_VAL      = DOWN ? '0 : LIMIT;
    localparam logic             START_IS_TERM = (START_VAL == TERM_VAL);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] step_val;
    logic             expired_q;
    logic             pulse_q;
    logic             pulse_d;
    logic             reload;
    logic             tick;
    logic             at_term;

    always_comb begin
        reload   = (game_state != STATE) || restart;
        tick     = (pre_q == PRE_LAST);
        at_term  = (cnt_q == TERM_VAL);
        step_val = DOWN ? (cnt_q - CNT_W'(1)) : (cnt_q + CNT_W'(1));
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        if (reload) begin
            // Reload never raises the strobe, even when start == terminal.
            pre_d = '0;
            cnt_d = START_VAL;
        end else if (!pause) begin
            if (tick) begin
                pre_d = '0;
                // Saturate: once terminal, ticks keep wrapping the prescaler
                // but leave the count alone.
                if (!at_term) begin
                    cnt_d   = step_val;
                    pulse_d = (step_val == TERM_VAL);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre_q     <= '0;
            cnt_q     <= START_VAL;
            expired_q <= START_IS_TERM;
            pulse_q   <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == TERM_VAL);
            pulse_q   <= pulse_d;
        end
    end

    assign count        = cnt_q;
    assign expired      = expired_q;
    assign expire_pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/game_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : game_timer_bank
// Description : Bank of NUM_CH independent game timers. Each channel is
//               enabled by its own GameState code and has its own prescaler,
//               limit and count direction.
// Ports       : Clk          in  clock, rising edge
//               Reset_n      in  synchronous active-low reset
//               GameState    in  current game state code
//               Pause        in  global freeze of all prescalers and counts
//               Restart      in  per-channel reload request
//               count        out packed channel counts, channel i at
//                                [CNT_W*i +: CNT_W]
//               expired      out per-channel terminal-value level
//               expire_pulse out per-channel one-cycle terminal-entry strobe
// Revision    : 1.0 - initial release
// ============================================================================
module game_timer_bank
    import game_timer_bank_pkg::*;
#(
    parameter int                        NUM_CH   = 4,
    parameter int                        CNT_W    = 4,
    parameter int                        TICK_DIV = 50000000,
    parameter logic [NUM_CH*STATE_W-1:0] CH_STATE = {GS_PAUSE4, GS_PAUSE3, GS_KO, GS_PLAYING},
    parameter logic [NUM_CH*CNT_W-1:0]   CH_LIMIT = {NUM_CH{CNT_W'(15)}},
    parameter logic [NUM_CH-1:0]         CH_DOWN  = '0
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [STATE_W-1:0]        GameState,
    input  logic                      Pause,
    input  logic [NUM_CH-1:0]         Restart,
    output logic [NUM_CH*CNT_W-1:0]   count,
    output logic [NUM_CH-1:0]         expired,
    output logic [NUM_CH-1:0]         expire_pulse
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        game_timer_channel #(
            .CNT_W    (CNT_W),
            .TICK_DIV (TICK_DIV),
            .STATE    (CH_STATE[STATE_W*i +: STATE_W]),
            .LIMIT    (CH_LIMIT[CNT_W*i +: CNT_W]),
            .DOWN     (CH_DOWN[i])
        ) u_ch (
            .clk          (Clk),
            .reset_n      (Reset_n),
            .game_state   (GameState),
            .pause        (Pause),
            .restart      (Restart[i]),
            .count        (count[CNT_W*i +: CNT_W]),
            .expired      (expired[i]),
            .expire_pulse (expire_pulse[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_game_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_timer_bank
// Description : Self-checking bench for game_timer_bank. A per-channel
//               reference model predicts the outputs for each driven cycle;
//               predictions are queued and compared after the clock edge.
//               Directed scenarios add fixed-value checks on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_timer_bank;
    import game_timer_bank_pkg::*;

    localparam int          NUM_CH   = 4;
    localparam int          CNT_W    = 4;
    localparam int          TICK_DIV = 4;
    localparam logic [15:0] TB_STATE = {GS_PAUSE4, GS_PAUSE3, GS_PLAYING, GS_PLAYING};
    localparam logic [15:0] TB_LIMIT = {4'd15, 4'd15, 4'd2, 4'd3};
    localparam logic [3:0]  TB_DOWN  = 4'b0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  gs;
    logic        pause;
    logic [3:0]  restart;
    logic [15:0] count;
    logic [3:0]  expired;
    logic [3:0]  expire_pulse;

    typedef struct packed {
        logic [15:0] cnt;
        logic [3:0]  exp;
        logic [3:0]  pul;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    int   m_pre [NUM_CH];
    int   m_cnt [NUM_CH];
    logic m_pul [NUM_CH];

    always #5 clk = ~clk;

    game_timer_bank #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .TICK_DIV (TICK_DIV),
        .CH_STATE (TB_STATE),
        .CH_LIMIT (TB_LIMIT),
        .CH_DOWN  (TB_DOWN)
    ) dut (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .GameState    (gs),
        .Pause        (pause),
        .Restart      (restart),
        .count        (count),
        .expired      (expired),
        .expire_pulse (expire_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        if (obs !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then
    // compare them against the DUT after the edge.
    task automatic cycle(input logic r, input logic [3:0] g, input logic p, input logic [3:0] rs);
        exp_t e;
        int   start_v;
        int   term_v;
        @(negedge clk);
        rst_n   = r;
        gs      = g;
        pause   = p;
        restart = rs;
        for (int c = 0; c < NUM_CH; c++) begin
            start_v = TB_DOWN[c] ? int'(TB_LIMIT[4*c +: 4]) : 0;
            term_v  = TB_DOWN[c] ? 0 : int'(TB_LIMIT[4*c +: 4]);
            m_pul[c] = 1'b0;
            if (!r || (g != TB_STATE[4*c +: 4]) || rs[c]) begin
                m_pre[c] = 0;
                m_cnt[c] = start_v;
            end else if (!p) begin
                if (m_pre[c] == TICK_DIV - 1) begin
                    m_pre[c] = 0;
                    if (m_cnt[c] != term_v) begin
                        m_cnt[c] = TB_DOWN[c] ? m_cnt[c] - 1 : m_cnt[c] + 1;
                        m_pul[c] = (m_cnt[c] == term_v);
                    end
                end else begin
                    m_pre[c] = m_pre[c] + 1;
                end
            end
            e.cnt[4*c +: 4] = 4'(m_cnt[c]);
            e.exp[c]        = (m_cnt[c] == term_v);
            e.pul[c]        = m_pul[c];
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_count",  32'(count),        32'(e.cnt));
        check("sb_expired", 32'(expired),     32'(e.exp));
        check("sb_pulse",  32'(expire_pulse), 32'(e.pul));
    endtask

    initial begin
        int pc0;
        int pc1;
        int psum;
        rst_n   = 1'b0;
        gs      = GS_IDLE;
        pause   = 1'b0;
        restart = 4'h0;

        // Reset state: ch1 counts down from 2, all others start at 0.
        cycle(1'b0, GS_IDLE, 1'b0, 4'h0);
        check("rst_count",   32'(count),        32'h0020);
        check("rst_expired", 32'(expired),      32'h0);
        check("rst_pulse",   32'(expire_pulse), 32'h0);

        // Up channel 0 to 3 and down channel 1 to 0, then saturation.
        pc0 = 0;
        pc1 = 0;
        for (int n = 1; n <= 20; n++) begin
            cycle(1'b1, GS_PLAYING, 1'b0, 4'h0);
            pc0 += int'(expire_pulse[0]);
            pc1 += int'(expire_pulse[1]);
            if (n == 3)  check("ch0_pre_step",  32'(count[3:0]), 32'd0);
            if (n == 4)  check("ch0_step1",     32'(count[3:0]), 32'd1);
            if (n == 8)  check("ch0_step2",     32'(count[3:0]), 32'd2);
            if (n == 8)  check("ch1_zero",      32'(count[7:4]), 32'd0);
            if (n == 8)  check("ch1_pulse",     32'(expire_pulse[1]), 32'd1);
            if (n == 12) check("ch0_step3",     32'(count[3:0]), 32'd3);
            if (n == 12) check("ch0_pulse",     32'(expire_pulse[0]), 32'd1);
        end
        check("ch0_pulse_cnt", 32'(pc0), 32'd1);
        check("ch1_pulse_cnt", 32'(pc1), 32'd1);
        check("ch0_hold",      32'(count[3:0]), 32'd3);
        check("ch0_expired",   32'(expired[0]), 32'd1);
        check("ch1_nowrap",    32'(count[7:4]), 32'd0);

        // Pause freezes the count; the step resumes 2 active cycles later.
        cycle(1'b0, GS_IDLE, 1'b0, 4'h0);
        for (int n = 0; n < 6; n++)  cycle(1'b1, GS_PLAYING, 1'b0, 4'h0);
        for (int n = 0; n < 10; n++) cycle(1'b1, GS_PLAYING, 1'b1, 4'h0);
        check("pause_frozen", 32'(count[3:0]), 32'd1);
        cycle(1'b1, GS_PLAYING, 1'b0, 4'h0);
        check("pause_rel1", 32'(count[3:0]), 32'd1);
        cycle(1'b1, GS_PLAYING, 1'b0, 4'h0);
        check("pause_rel2", 32'(count[3:0]), 32'd2);

        // State excursion reloads the count and restarts the full delay.
        cycle(1'b0, GS_IDLE, 1'b0, 4'h0);
        for (int n = 0; n < 6; n++) cycle(1'b1, GS_PLAYING, 1'b0, 4'h0);
        cycle(1'b1, GS_END, 1'b0, 4'h0);
        check("gs_reload", 32'(count[3:0]), 32'd0);
        psum = 0;
        for (int n = 1; n <= 4; n++) begin
            cycle(1'b1, GS_PLAYING, 1'b0, 4'h0);
            psum += int'(expire_pulse[0]);
            if (n == 3) check("gs_delay3", 32'(count[3:0]), 32'd0);
            if (n == 4) check("gs_delay4", 32'(count[3:0]), 32'd1);
        end
        check("gs_no_pulse", 32'(psum), 32'd0);

        // Restart wins over Pause; then reset mid-count.
        cycle(1'b1, GS_PLAYING, 1'b0, 4'h0);
        cycle(1'b1, GS_PLAYING, 1'b1, 4'h1);
        check("restart_pause", 32'(count[3:0]), 32'd0);
        for (int n = 0; n < 5; n++) cycle(1'b1, GS_PLAYING, 1'b0, 4'h0);
        cycle(1'b0, GS_PLAYING, 1'b0, 4'h0);
        check("midrst_count", 32'(count),        32'h0020);
        check("midrst_pulse", 32'(expire_pulse), 32'h0);

        // Mixed traffic against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [3:0] g;
            case ($urandom_range(0, 4))
                0:       g = GS_END;
                1:       g = GS_PAUSE3;
                default: g = GS_PLAYING;
            endcase
            cycle(($urandom_range(0, 39) != 0), g,
                  ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)));
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_timer_bank.md
GAME_TIMER_BANK -- requirements
Module: game_timer_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of independent timer channels.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of each channel count.
REQ-003 The block SHALL have parameter TICK_DIV, default 50000000: clock cycles per count tick, legal range 2 or more.
REQ-004 The block SHALL have parameter CH_STATE, NUM_CH*4 bits, default {4'b1001,4'b1000,4'b0110,4'b0011}: GameState code that enables each channel; channel i uses bits [4i+3:4i].
REQ-005 The block SHALL have parameter CH_LIMIT, NUM_CH*CNT_W bits, default all channels = 15: terminal value for up channels and start value for down channels.
REQ-006 The block SHALL have parameter CH_DOWN, NUM_CH bits, default 0: per-channel count direction, 1 = count down.
REQ-007 Clk  in  1  the single clock; all state changes on its rising edge.
REQ-008 Reset_n  in  1  reset; synchronous and active-low.
REQ-009 GameState  in  4  current game state code.
REQ-010 Pause  in  1  global freeze; when high, all prescalers and counts hold.
REQ-011 Restart  in  NUM_CH  per-channel reload request, sampled each cycle.
REQ-012 count  out  NUM_CH*CNT_W  current channel counts, registered; channel i at [CNT_W*i+CNT_W-1:CNT_W*i].
REQ-013 expired  out  NUM_CH  level; high while the channel count equals its terminal value.
REQ-014 expire_pulse  out  NUM_CH  one-cycle strobe on entry to the terminal value.

Function
REQ-015 Channel i SHALL be active when GameState == CH_STATE[i] and Pause == 0.
REQ-016 The start value SHALL be 0 for up channels and CH_LIMIT[i] for down channels; the terminal value SHALL be CH_LIMIT[i] for up channels and 0 for down channels.
REQ-017 Each channel SHALL own a prescaler of width clog2(TICK_DIV) counting 0..TICK_DIV-1 while the channel is active.
REQ-018 A tick SHALL occur on the cycle the prescaler holds TICK_DIV-1; the prescaler then wraps to 0.
REQ-019 On a tick, the count SHALL move one step toward the terminal value: +1 for up, -1 for down.
REQ-020 At the terminal value, the count SHALL saturate and hold; the count SHALL never wrap.
REQ-021 When GameState != CH_STATE[i], the channel SHALL load prescaler = 0 and count = start value on every cycle.
REQ-022 Restart[i] = 1 SHALL load prescaler = 0 and count = start value on the next edge.
REQ-023 While Pause = 1 and GameState == CH_STATE[i], the channel prescaler and count SHALL hold.
REQ-024 Priority SHALL be: Reset_n low, then state mismatch, then Restart, then Pause, then normal counting.
REQ-025 expired[i] SHALL be a registered output equal to (count == terminal value); it is therefore high during reload if CH_LIMIT[i] == 0.
REQ-026 expire_pulse[i] SHALL be high for exactly the one cycle after the edge on which the count steps into the terminal value.
REQ-027 expire_pulse SHALL NOT fire on reload or reset, even if the start value equals the terminal value.
REQ-028 Count latency SHALL be: the first step occurs TICK_DIV cycles after the channel becomes active from reload; each later step occurs every TICK_DIV active cycles.
REQ-029 Channels SHALL be fully independent; several channels SHALL NOT share a prescaler.

Reset
REQ-030 On a Clk edge with Reset_n = 0, every prescaler SHALL be 0 and every count SHALL equal its start value.
REQ-031 On that edge, expire_pulse SHALL be 0 and expired SHALL equal (start value == terminal value).
REQ-032 Reset_n asserted mid-count SHALL abort the count with no expire_pulse.

Structure
REQ-033 The GameState codes (PLAYING 4'b0011, KO 4'b0110, PAUSE3 4'b1000, PAUSE4 4'b1001, IDLE 4'b0000, END 4'b0101) and the 4-bit state width SHALL live in the shared game package.
REQ-034 The bank SHALL be a generate loop of NUM_CH instances of one sub-module, game_timer_channel, with scalar parameters CNT_W, TICK_DIV, STATE, LIMIT and DOWN.

Verification
REQ-035 Bench SHALL use NUM_CH=4, TICK_DIV=4 and CH_LIMIT ch0 = 3 up, ch1 = 2 down; other parameters at default unless stated.
REQ-036 GameState=0011 held 20 cycles -> ch0 count 0,1,2,3 at cycles 4, 8, 12; expire_pulse[0] exactly once; count then holds at 3 with expired[0]=1.
REQ-037 ch1 STATE=0011 DOWN=1, GameState=0011 -> count 2,1,0; expire_pulse[1] once at entry to 0; no wrap to 3.
REQ-038 GameState=0011 for 6 cycles, Pause=1 for 10 cycles, then Pause=0 -> count frozen at 1; next step arrives 2 active cycles after release.
REQ-039 Mid-count GameState changes 0011->0101->0011 -> count reloads to 0 and restarts the full TICK_DIV delay; no expire_pulse.
REQ-040 Restart[0] and Pause both high on the same cycle -> reload wins (count=0); Reset_n=0 mid-count -> all counts reach their start values on the next edge with expire_pulse=0.
